stim_pattern_gen: RTL and testbench

Parametrised, synthesizable stimulus generator and response compactor for gate-level benchmark netlists such as the ISCAS c432 clocked-input wrapper. It drives N_CH DUT primary inputs with one of four programmable pattern modes, holding each vector for a programmable number of clocks, and compacts the DUT outputs into a MISR signature. It sits between the bench or an on-chip controller and the flopped-input netlist, and replaces free-running per-input toggle processes with a bounded, repeatable vector run.

---
 rtl/stim_pattern_gen_if.sv | 35 +++
 rtl/stim_pattern_gen.sv | 190 +++++++++++++++++++
 tb/tb_stim_pattern_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stim_pattern_gen_if.sv
// Bus bundle between a stimulus controller (bench or on-chip sequencer plus
// the netlist under test) and stim_pattern_gen. The master side owns the run
// controls and the DUT response; the slave side is the generator, which
// drives the vector, the status flags and the signature.
interface stim_pattern_gen_if #(
  parameter int N_CH  = 36,
  parameter int N_OUT = 7,
  parameter int DIV_W = 8,
  parameter int VEC_W = 16
);

  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [VEC_W-1:0] num_vec;
  logic [N_CH-1:0]  seed;
  logic [N_CH-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [VEC_W-1:0] vec_cnt;
  logic [N_OUT-1:0] signature;

  modport master (
    output start, abort, mode, div, num_vec, seed, dut_out,
    input  dut_in, busy, done, vec_cnt, signature
  );

  modport slave (
    input  start, abort, mode, div, num_vec, seed, dut_out,
    output dut_in, busy, done, vec_cnt, signature
  );

endinterface

// File: rtl/stim_pattern_gen.sv
// stim_pattern_gen: drives N_CH primary inputs of a flopped-input benchmark
// netlist with walk-toggle, LFSR, counter or hold patterns, each vector held
// for div clocks, and compacts the netlist outputs into a MISR signature.
//
// Build option: define STIM_MISR_EN to compile in the MISR. Without it the
// signature output is tied to zero and dut_out is ignored; the run sequencing,
// dut_in and vec_cnt behave identically in both builds.
module stim_pattern_gen #(
  parameter int               N_CH      = 36,
  parameter int               N_OUT     = 7,
  parameter int               DIV_W     = 8,
  parameter int               VEC_W     = 16,
  parameter logic [N_CH-1:0]  LFSR_TAPS = 36'h801000000,
  parameter logic [N_OUT-1:0] MISR_POLY = 7'h03
) (
  input  logic               clk,
  input  logic               reset,
  stim_pattern_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [DIV_W-1:0] DIV_ZERO  = '0;
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [VEC_W-1:0] VEC_ZERO  = '0;
  localparam logic [VEC_W-1:0] VEC_ONE   = VEC_W'(1);
  localparam logic [VEC_W:0]   VEC_ONE_X = (VEC_W+1)'(1);
  localparam logic [N_CH-1:0]  CH_ZERO   = '0;
  localparam logic [N_CH-1:0]  CH_ONE    = N_CH'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = '0;
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CH - 1);

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [VEC_W-1:0] num_q;
  logic [DIV_W-1:0] div_cnt;
  logic [VEC_W-1:0] vec_cnt;
  logic [N_CH-1:0]  vec_q;
  logic [IDX_W-1:0] walk_idx;

  logic             start_run;
  logic [DIV_W-1:0] div_last;
  logic             step;
  logic [VEC_W:0]   vec_cnt_p1;
  logic             last_vec;
  logic             vec_sat;
  logic [N_CH-1:0]  seed_eff;
  logic [N_CH-1:0]  vec_nxt;
  logic [IDX_W-1:0] walk_nxt;

  // A run is only accepted from IDLE; start in any other state is ignored.
  assign start_run = (state == IDLE) && bus.start;

  // div_eff-1, with a programmed divider of 0 behaving like 1.
  assign div_last = (div_q == DIV_ZERO) ? DIV_ZERO : (div_q - DIV_ONE);

  // A step boundary is the last clock a vector is held; the capture happens here.
  assign step = (state == RUN) && (div_cnt >= div_last);

  // One extra bit keeps vec_cnt+1 from aliasing when compared to num_vec.
  assign vec_cnt_p1 = {1'b0, vec_cnt} + VEC_ONE_X;
  assign last_vec   = (vec_cnt_p1 == {1'b0, num_q});
  assign vec_sat    = &vec_cnt;

  // The LFSR cannot leave the all-zero state, so a zero seed becomes all-ones.
  assign seed_eff = ((bus.mode == 2'd1) && (bus.seed == CH_ZERO)) ? {N_CH{1'b1}} : bus.seed;

  // walk_idx tracks (vector index mod N_CH) without a hardware divider.
  assign walk_nxt = (walk_idx == IDX_LAST) ? IDX_ZERO : (walk_idx + IDX_ONE);

  // Next vector for the latched mode, applied when the current one is captured.
  always_comb begin
    vec_nxt = vec_q;
    case (mode_q)
      2'd0:    vec_nxt = vec_q ^ (CH_ONE << walk_idx);
      2'd1:    vec_nxt = (vec_q >> 1) ^ (vec_q[0] ? LFSR_TAPS : CH_ZERO);
      2'd2:    vec_nxt = vec_q + CH_ONE;
      default: vec_nxt = vec_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run sequencing; abort beats the final step boundary in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.num_vec == VEC_ZERO) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (step && last_vec) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Run parameters, divider, vector counter and the driven vector. The final
  // vector, and any vector cut short by abort, stays on dut_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= 2'd0;
      div_q    <= DIV_ZERO;
      num_q    <= VEC_ZERO;
      div_cnt  <= DIV_ZERO;
      vec_cnt  <= VEC_ZERO;
      vec_q    <= CH_ZERO;
      walk_idx <= IDX_ZERO;
    end else if (start_run) begin
      mode_q   <= bus.mode;
      div_q    <= bus.div;
      num_q    <= bus.num_vec;
      div_cnt  <= DIV_ZERO;
      vec_cnt  <= VEC_ZERO;
      vec_q    <= seed_eff;
      walk_idx <= IDX_ZERO;
    end else if (step) begin
      div_cnt  <= DIV_ZERO;
      vec_cnt  <= vec_sat ? vec_cnt : (vec_cnt + VEC_ONE);
      walk_idx <= walk_nxt;
      if (!last_vec && !bus.abort) begin
        vec_q <= vec_nxt;
      end
    end else if (state == RUN) begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

`ifdef STIM_MISR_EN
  logic [N_OUT-1:0] sig_q;
  logic [N_OUT-1:0] sig_nxt;

  // Shift with polynomial feedback, then fold in the current response.
  always_comb begin
    sig_nxt = ({sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? MISR_POLY : '0)) ^ bus.dut_out;
  end

  // Signature register: cleared per run, updated on every capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= '0;
    end else if (start_run) begin
      sig_q <= '0;
    end else if (step) begin
      sig_q <= sig_nxt;
    end
  end

  assign bus.signature = sig_q;
`else
  logic unused_dut_out;

  assign unused_dut_out = ^bus.dut_out;
  assign bus.signature  = '0;
`endif

  assign bus.dut_in  = vec_q;
  assign bus.vec_cnt = vec_cnt;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Directed bench for stim_pattern_gen. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, so "cycle n" below is the
// interval following edge n-1 with edge 0 being the edge that samples start.
module tb_stim_pattern_gen;

`ifdef STIM_MISR_EN
  localparam bit MISR_ON = 1'b1;
`else
  localparam bit MISR_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  stim_pattern_gen_if bus ();

  stim_pattern_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Program a run and pulse start across edge 0; returns in cycle 1.
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] d,
                               input logic [15:0] n, input logic [35:0] s);
    bus.mode    = m;
    bus.div     = d;
    bus.num_vec = n;
    bus.seed    = s;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.mode    = 2'd0;
    bus.div     = 8'd0;
    bus.num_vec = 16'd0;
    bus.seed    = 36'd0;
    bus.dut_out = 7'd0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_dut_in", 64'(bus.dut_in), 64'h0);
    checkOutput("rst_vec_cnt", 64'(bus.vec_cnt), 64'h0);
    checkOutput("rst_signature", 64'(bus.signature), 64'h0);
    checkOutput("rst_busy", 64'(bus.busy), 64'h0);
    checkOutput("rst_done", 64'(bus.done), 64'h0);

    // Reset mid-run: counter mode, ten vectors, nonzero response.
    bus.dut_out = 7'h55;
    applyStimulus(2'd2, 8'd1, 16'd10, 36'h0);
    tick();
    tick();
    tick();
    checkOutput("mid_dut_in_c4", 64'(bus.dut_in), 64'h3);
    checkOutput("mid_vec_cnt_c4", 64'(bus.vec_cnt), 64'h3);
    checkOutput("mid_sig_c4", 64'(bus.signature), MISR_ON ? 64'h2E : 64'h0);
    reset = 1'b1;
    tick();
    checkOutput("mrst_dut_in", 64'(bus.dut_in), 64'h0);
    checkOutput("mrst_vec_cnt", 64'(bus.vec_cnt), 64'h0);
    checkOutput("mrst_signature", 64'(bus.signature), 64'h0);
    checkOutput("mrst_busy", 64'(bus.busy), 64'h0);
    checkOutput("mrst_done", 64'(bus.done), 64'h0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("mrst_idle_after", 64'(bus.busy), 64'h0);

    // Walk-toggle from zero, four vectors.
    bus.dut_out = 7'h00;
    applyStimulus(2'd0, 8'd1, 16'd4, 36'h0);
    checkOutput("walk_c1", 64'(bus.dut_in), 64'h0);
    checkOutput("walk_busy_c1", 64'(bus.busy), 64'h1);
    tick();
    checkOutput("walk_c2", 64'(bus.dut_in), 64'h1);
    checkOutput("walk_vec_cnt_c2", 64'(bus.vec_cnt), 64'h1);
    tick();
    checkOutput("walk_c3", 64'(bus.dut_in), 64'h3);
    tick();
    checkOutput("walk_c4", 64'(bus.dut_in), 64'h7);
    checkOutput("walk_done_c4", 64'(bus.done), 64'h0);
    tick();
    checkOutput("walk_done_c5", 64'(bus.done), 64'h1);
    checkOutput("walk_busy_c5", 64'(bus.busy), 64'h1);
    checkOutput("walk_vec_cnt_c5", 64'(bus.vec_cnt), 64'h4);
    checkOutput("walk_hold_c5", 64'(bus.dut_in), 64'h7);
    tick();
    checkOutput("walk_done_c6", 64'(bus.done), 64'h0);
    checkOutput("walk_busy_c6", 64'(bus.busy), 64'h0);
    checkOutput("walk_hold_c6", 64'(bus.dut_in), 64'h7);

    // Counter wrap from all-ones.
    applyStimulus(2'd2, 8'd1, 16'd3, 36'hFFFFFFFFF);
    checkOutput("cnt_c1", 64'(bus.dut_in), 64'hFFFFFFFFF);
    tick();
    checkOutput("cnt_c2", 64'(bus.dut_in), 64'h0);
    tick();
    checkOutput("cnt_c3", 64'(bus.dut_in), 64'h1);
    tick();
    checkOutput("cnt_done_c4", 64'(bus.done), 64'h1);
    checkOutput("cnt_hold_c4", 64'(bus.dut_in), 64'h1);
    tick();

    // LFSR with zero seed replaced by all-ones.
    applyStimulus(2'd1, 8'd1, 16'd2, 36'h0);
    checkOutput("lfsr0_c1", 64'(bus.dut_in), 64'hFFFFFFFFF);
    tick();
    checkOutput("lfsr0_c2", 64'(bus.dut_in), 64'hFFEFFFFFF);
    tick();
    checkOutput("lfsr0_done_c3", 64'(bus.done), 64'h1);
    tick();

    // LFSR with seed 1: a set LSB folds the taps in.
    applyStimulus(2'd1, 8'd1, 16'd2, 36'h1);
    checkOutput("lfsr1_c1", 64'(bus.dut_in), 64'h1);
    tick();
    checkOutput("lfsr1_c2", 64'(bus.dut_in), 64'h801000000);
    tick();
    tick();

    // Zero vectors: straight to DONE with the seed on dut_in.
    applyStimulus(2'd0, 8'd1, 16'd0, 36'h12345);
    checkOutput("nv0_done_c1", 64'(bus.done), 64'h1);
    checkOutput("nv0_busy_c1", 64'(bus.busy), 64'h1);
    checkOutput("nv0_dut_in_c1", 64'(bus.dut_in), 64'h12345);
    checkOutput("nv0_vec_cnt_c1", 64'(bus.vec_cnt), 64'h0);
    tick();
    checkOutput("nv0_busy_c2", 64'(bus.busy), 64'h0);

    // Divider of 3 with a stray start during the run and an abort in cycle 5.
    applyStimulus(2'd2, 8'd3, 16'd5, 36'h0);
    checkOutput("div_c1", 64'(bus.dut_in), 64'h0);
    tick();
    bus.start = 1'b1;
    bus.mode  = 2'd0;
    bus.seed  = 36'hABC;
    tick();
    bus.start = 1'b0;
    checkOutput("div_c3", 64'(bus.dut_in), 64'h0);
    checkOutput("div_vec_cnt_c3", 64'(bus.vec_cnt), 64'h0);
    tick();
    checkOutput("div_c4", 64'(bus.dut_in), 64'h1);
    checkOutput("div_vec_cnt_c4", 64'(bus.vec_cnt), 64'h1);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("abort_busy_c6", 64'(bus.busy), 64'h0);
    checkOutput("abort_done_c6", 64'(bus.done), 64'h0);
    checkOutput("abort_vec_cnt_c6", 64'(bus.vec_cnt), 64'h1);
    checkOutput("abort_dut_in_c6", 64'(bus.dut_in), 64'h1);
    tick();
    checkOutput("abort_done_c7", 64'(bus.done), 64'h0);

    // Abort on the final boundary: capture happens, done does not.
    bus.dut_out = 7'h7F;
    applyStimulus(2'd3, 8'd1, 16'd2, 36'h5);
    checkOutput("afin_c1", 64'(bus.dut_in), 64'h5);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("afin_busy", 64'(bus.busy), 64'h0);
    checkOutput("afin_done", 64'(bus.done), 64'h0);
    checkOutput("afin_vec_cnt", 64'(bus.vec_cnt), 64'h2);
    checkOutput("afin_sig", 64'(bus.signature), MISR_ON ? 64'h02 : 64'h0);
    checkOutput("afin_dut_in", 64'(bus.dut_in), 64'h5);
    tick();

    // MISR run with div 0 treated as 1.
    bus.dut_out = 7'h01;
    applyStimulus(2'd3, 8'd0, 16'd2, 36'h0);
    checkOutput("misr_sig_clr_c1", 64'(bus.signature), 64'h0);
    tick();
    checkOutput("misr_sig_c2", 64'(bus.signature), MISR_ON ? 64'h01 : 64'h0);
    checkOutput("misr_done_c2", 64'(bus.done), 64'h0);
    tick();
    checkOutput("misr_done_c3", 64'(bus.done), 64'h1);
    checkOutput("misr_sig_c3", 64'(bus.signature), MISR_ON ? 64'h03 : 64'h0);
    checkOutput("misr_vec_cnt_c3", 64'(bus.vec_cnt), 64'h2);
    tick();
    checkOutput("misr_busy_c4", 64'(bus.busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
